host_bus_bridge: RTL and testbench

Host-side bus initiator for the XuLA2 build. Consumes a byte command stream from the host FIFO (HostIoComm downstream side) and issues single-word reads and writes on the same 30-bit word-address CPU bus the yarvi core drives. It returns read data and write acknowledges through the host FIFO upstream side. Used for program loading and memory/peripheral inspection, in place of or alongside the core.

---
 rtl/host_bus_pkg.sv | 20 ++
 rtl/host_byte_tx.sv | 43 ++++
 rtl/host_bus_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_host_bus_bridge.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_bus_pkg.sv
// host_bus_pkg: shared state encoding and protocol byte constants for the
// host bus bridge (command parser, bus strobes and reply sequencing).
package host_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OP,
    ST_ADDR,
    ST_DATA,
    ST_BUS_WR,
    ST_BUS_RD,
    ST_RD_WAIT,
    ST_REPLY
  } state_e;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] ACK_BYTE = 8'h4B;

endpackage

// File: rtl/host_byte_tx.sv
// host_byte_tx: paces bytes into the upstream host FIFO. A byte is accepted
// only while no push is in flight and the FIFO has room, giving one push
// pulse per accepted byte and at most one byte every two cycles.
module host_byte_tx (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       tx_full,
  output logic [7:0] tx_data,
  output logic       tx_add
);

  logic       tx_add_q, tx_add_d;
  logic [7:0] tx_data_q, tx_data_d;

  assign in_ready = !tx_add_q && !tx_full;
  assign tx_add   = tx_add_q;
  assign tx_data  = tx_data_q;

  // Next push pulse and held byte value.
  always_comb begin
    tx_add_d  = 1'b0;
    tx_data_d = tx_data_q;
    if (in_valid && in_ready) begin
      tx_add_d  = 1'b1;
      tx_data_d = in_data;
    end
  end

  // Push pulse and data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_add_q  <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      tx_add_q  <= tx_add_d;
      tx_data_q <= tx_data_d;
    end
  end

endmodule

// File: rtl/host_bus_bridge.sv
// host_bus_bridge: parses 'W'/'R' byte commands from the host FIFO, issues
// single-word bus strobes and returns the ack or read data to the host.
// Optional inter-byte abort timer: define HOST_BUS_BRIDGE_TIMEOUT_EN.
module host_bus_bridge
  import host_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        rx_pop,
  output logic [7:0]  tx_data,
  output logic        tx_add,
  input  logic        tx_full,
  output logic [29:0] address,
  output logic [31:0] writedata,
  output logic        writeenable,
  output logic [3:0]  byteena,
  output logic        readenable,
  input  logic [31:0] readdata,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [31:0] addr_sr_q, addr_sr_d;
  logic [31:0] data_sr_q, data_sr_d;
  logic        rx_pop_q, rx_pop_d;
  logic [29:0] address_q, address_d;
  logic [31:0] writedata_q, writedata_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic [3:0]  be_q, be_d;
  logic        rx_valid;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_byte;
  logic        to_expired;

  // A head byte is usable only when no pop is still in flight.
  assign rx_valid    = !rx_empty && !rx_pop_q;
  assign rx_pop      = rx_pop_q;
  assign address     = address_q;
  assign writedata   = writedata_q;
  assign writeenable = we_q;
  assign readenable  = re_q;
  assign byteena     = be_q;
  assign busy        = (state_q != ST_IDLE);

`ifdef HOST_BUS_BRIDGE_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        rx_phase;

  assign rx_phase   = (state_q == ST_OP) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign to_expired = rx_phase && (to_cnt_q >= 32'(TIMEOUT_CYCLES));

  // Inter-byte timer: restarts on every pop, idle outside the receive states.
  always_comb begin
    to_cnt_d = 32'd0;
    if (rx_phase && !rx_pop_q) to_cnt_d = to_cnt_q + 32'd1;
  end

  // Timer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) to_cnt_q <= 32'd0;
    else          to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign to_expired     = 1'b0;
`endif

  // Command parser, bus strobe generation and reply sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opcode_d    = opcode_q;
    addr_sr_d   = addr_sr_q;
    data_sr_d   = data_sr_q;
    rx_pop_d    = 1'b0;
    address_d   = address_q;
    writedata_d = writedata_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    be_d        = 4'h0;
    tx_valid    = 1'b0;
    tx_byte     = data_sr_q[7:0];
    case (state_q)
      ST_IDLE: if (!rx_empty) state_d = ST_OP;
      ST_OP: begin
        if (rx_valid) begin
          rx_pop_d = 1'b1;
          cnt_d    = 2'd0;
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            opcode_d = rx_data;
            state_d  = ST_ADDR;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          rx_pop_d  = 1'b1;
          addr_sr_d = {rx_data, addr_sr_q[31:8]};
          cnt_d     = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = (opcode_q == OP_WRITE) ? ST_DATA : ST_BUS_RD;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          rx_pop_d  = 1'b1;
          data_sr_d = {rx_data, data_sr_q[31:8]};
          cnt_d     = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ST_BUS_WR;
        end
      end
      ST_BUS_WR: begin
        address_d   = addr_sr_q[31:2];
        writedata_d = data_sr_q;
        we_d        = 1'b1;
        be_d        = 4'hF;
        data_sr_d   = {24'h0, ACK_BYTE};
        cnt_d       = 2'd0;
        state_d     = ST_REPLY;
      end
      ST_BUS_RD: begin
        address_d = addr_sr_q[31:2];
        re_d      = 1'b1;
        be_d      = 4'hF;
        state_d   = ST_RD_WAIT;
      end
      // readdata is valid the cycle after the strobe, i.e. once re_q drops.
      ST_RD_WAIT: begin
        if (!re_q) begin
          data_sr_d = readdata;
          cnt_d     = 2'd3;
          state_d   = ST_REPLY;
        end
      end
      ST_REPLY: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          data_sr_d = {8'h00, data_sr_q[31:8]};
          if (cnt_q == 2'd0) state_d = ST_IDLE;
          else               cnt_d   = cnt_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (to_expired) begin
      state_d  = ST_IDLE;
      rx_pop_d = 1'b0;
      cnt_d    = 2'd0;
    end
  end

  // Control, shift and registered bus output state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      opcode_q    <= 8'h00;
      addr_sr_q   <= 32'h0;
      data_sr_q   <= 32'h0;
      rx_pop_q    <= 1'b0;
      address_q   <= 30'h0;
      writedata_q <= 32'h0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      be_q        <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opcode_q    <= opcode_d;
      addr_sr_q   <= addr_sr_d;
      data_sr_q   <= data_sr_d;
      rx_pop_q    <= rx_pop_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      we_q        <= we_d;
      re_q        <= re_d;
      be_q        <= be_d;
    end
  end

  host_byte_tx u_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (tx_valid),
    .in_data  (tx_byte),
    .in_ready (tx_ready),
    .tx_full  (tx_full),
    .tx_data  (tx_data),
    .tx_add   (tx_add)
  );

endmodule

// File: tb/tb_host_bus_bridge.sv
// tb_host_bus_bridge: host FIFO, bus memory and command-level reference model
// around host_bus_bridge. Timeout scenario runs when
// HOST_BUS_BRIDGE_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 20).
module tb_host_bus_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_empty;
  logic        rx_pop;
  logic [7:0]  tx_data;
  logic        tx_add;
  logic        tx_full;
  logic [29:0] address;
  logic [31:0] writedata;
  logic        writeenable;
  logic [3:0]  byteena;
  logic        readenable;
  logic [31:0] readdata;
  logic        busy;

  always #5 clk = ~clk;

  host_bus_bridge #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_empty(rx_empty),
    .rx_pop(rx_pop), .tx_data(tx_data), .tx_add(tx_add), .tx_full(tx_full),
    .address(address), .writedata(writedata), .writeenable(writeenable),
    .byteena(byteena), .readenable(readenable), .readdata(readdata), .busy(busy)
  );

  // ---------------- environment ----------------
  logic [7:0]  rx_buf [0:4095];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  bit rx_stall = 0, full_rand = 0, tx_hold = 0;
  bit rand_rx_en = 0, rand_full_en = 0;
  bit force_rd_en = 0;
  logic [31:0] force_rd_val = 32'h0;

  assign rx_empty = (rd_ptr == wr_ptr) || rx_stall;
  assign rx_data  = rx_buf[rd_ptr % 4096];
  assign tx_full  = tx_hold || full_rand;

  logic [7:0]  tx_log[$];
  logic [29:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [29:0] rd_addr_log[$];
  logic [31:0] bus_mem[logic [29:0]];
  bit          rd_pend = 0;
  logic [31:0] rd_val = 32'h0;
  bit prev_pop = 0, prev_add = 0;
  int v_overlap = 0, v_be = 0, v_we_t = 0, v_re_t = 0, v_pop_b2b = 0, v_add_b2b = 0;

  function automatic logic [31:0] mem_default(input logic [29:0] a);
    return {a[15:0], a[15:0]} ^ 32'h5A3C_96E1;
  endfunction

  // Monitor / FIFO / bus model, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_pop && tx_add) v_overlap++;
    if ((writeenable || readenable) ? (byteena !== 4'hF) : (byteena !== 4'h0)) v_be++;
    if (writeenable && !prev_pop) v_we_t++;
    if (readenable && !prev_pop) v_re_t++;
    if (rx_pop && prev_pop) v_pop_b2b++;
    if (tx_add && prev_add) v_add_b2b++;
    if (rx_pop) rd_ptr++;
    if (tx_add) tx_log.push_back(tx_data);
    if (writeenable) begin
      bus_mem[address] = writedata;
      wr_addr_log.push_back(address);
      wr_data_log.push_back(writedata);
    end
    if (readenable) begin
      rd_addr_log.push_back(address);
      rd_pend = 1;
      rd_val = force_rd_en ? force_rd_val :
               (bus_mem.exists(address) ? bus_mem[address] : mem_default(address));
    end else begin
      rd_pend = 0;
    end
    prev_pop  = rx_pop;
    prev_add  = tx_add;
    rx_stall  = rand_rx_en && ($urandom_range(0, 3) == 0);
    full_rand = rand_full_en && ($urandom_range(0, 2) == 0);
  end

  // Read data is valid only during the cycle after the read strobe.
  always @(posedge clk) begin
    #1;
    readdata = rd_pend ? rd_val : $urandom;
  end

  // ---------------- reference model ----------------
  logic [31:0] m_mem[logic [29:0]];
  logic [7:0]  exp_tx[$];
  logic [29:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  int          exp_rd;
  int n_checks = 0, n_fail = 0;

  task automatic model_stream(input logic [7:0] b[$]);
    int i = 0;
    while (i < b.size()) begin
      logic [7:0] op;
      int need;
      op = b[i];
      i++;
      if (op == 8'h57 || op == 8'h52) begin
        logic [31:0] a, d;
        need = (op == 8'h57) ? 8 : 4;
        if (i + need > b.size()) break;
        a = {b[i+3], b[i+2], b[i+1], b[i]};
        if (op == 8'h57) begin
          d = {b[i+7], b[i+6], b[i+5], b[i+4]};
          m_mem[a[31:2]] = d;
          exp_wa.push_back(a[31:2]);
          exp_wd.push_back(d);
          exp_tx.push_back(8'h4B);
        end else begin
          d = m_mem.exists(a[31:2]) ? m_mem[a[31:2]] : mem_default(a[31:2]);
          exp_rd++;
          for (int k = 0; k < 4; k++) exp_tx.push_back(d[8*k +: 8]);
        end
        i += need;
      end
    end
  endtask

  task automatic clear_exp();
    exp_tx.delete(); exp_wa.delete(); exp_wd.delete(); exp_rd = 0;
  endtask

  function automatic bit tx_matches(input int base);
    if (tx_log.size() != base + exp_tx.size()) return 0;
    foreach (exp_tx[k]) if (tx_log[base + k] !== exp_tx[k]) return 0;
    return 1;
  endfunction

  function automatic bit wr_matches(input int base);
    if (wr_addr_log.size() != base + exp_wa.size()) return 0;
    foreach (exp_wa[k])
      if (wr_addr_log[base + k] !== exp_wa[k] || wr_data_log[base + k] !== exp_wd[k]) return 0;
    return 1;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_bytes(input logic [7:0] b[$]);
    foreach (b[j]) begin
      rx_buf[wr_ptr % 4096] = b[j];
      wr_ptr++;
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int stable = 0;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (rd_ptr == wr_ptr && busy === 1'b0) stable++;
      else stable = 0;
      if (stable >= 4) begin ok = 1; break; end
    end
  endtask

  function automatic logic [78:0] all_outs();
    return {rx_pop, tx_add, writeenable, readenable, busy, byteena, tx_data, address, writedata};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 0;
    tick();
    n_checks++;
    if (all_outs() !== 79'h0) begin n_fail++; $display("FAIL reset_outputs: got %h required 0", all_outs()); end
    reset_n = 1;
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_write();
    logic [7:0] b[$] = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h20, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    int tb0 = tx_log.size(), wb0 = wr_addr_log.size(), rb0 = rd_addr_log.size();
    bit ok;
    clear_exp(); model_stream(b); send_bytes(b); wait_done(500, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL write_done: got timeout required completion"); end
    n_checks++;
    if (wr_addr_log.size() != wb0 + 1) begin n_fail++; $display("FAIL write_count: got %0d required 1", wr_addr_log.size() - wb0); end
    else begin
      n_checks++;
      if (wr_addr_log[wb0] !== 30'h08000004) begin n_fail++; $display("FAIL write_addr: got %h required 08000004", wr_addr_log[wb0]); end
      n_checks++;
      if (wr_data_log[wb0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_data: got %h required deadbeef", wr_data_log[wb0]); end
    end
    n_checks++;
    if (tx_log.size() != tb0 + 1 || tx_log[tb0] !== 8'h4B) begin n_fail++; $display("FAIL write_ack: got %0d bytes required one 4B", tx_log.size() - tb0); end
    n_checks++;
    if (rd_addr_log.size() != rb0) begin n_fail++; $display("FAIL write_no_read: got %0d reads required 0", rd_addr_log.size() - rb0); end
  endtask

  task automatic test_read();
    logic [7:0] b[$] = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h00};
    logic [31:0] got;
    int tb0 = tx_log.size(), wb0 = wr_addr_log.size(), rb0 = rd_addr_log.size();
    bit ok;
    force_rd_en = 1; force_rd_val = 32'h12345678;
    send_bytes(b); wait_done(500, ok);
    force_rd_en = 0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL read_done: got timeout required completion"); end
    n_checks++;
    if (rd_addr_log.size() != rb0 + 1 || rd_addr_log[rb0] !== 30'h2) begin n_fail++; $display("FAIL read_strobe: got %0d strobes required one at address 2", rd_addr_log.size() - rb0); end
    got = 32'h0;
    if (tx_log.size() == tb0 + 4) got = {tx_log[tb0], tx_log[tb0+1], tx_log[tb0+2], tx_log[tb0+3]};
    n_checks++;
    if (got !== 32'h78563412) begin n_fail++; $display("FAIL read_reply: got %h required 78563412 (%0d bytes)", got, tx_log.size() - tb0); end
    n_checks++;
    if (wr_addr_log.size() != wb0) begin n_fail++; $display("FAIL read_no_write: got %0d writes required 0", wr_addr_log.size() - wb0); end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] b[$] = '{8'h00, 8'h52, 8'h04, 8'h00, 8'h00, 8'h00};
    int tb0 = tx_log.size(), wb0 = wr_addr_log.size(), rb0 = rd_addr_log.size();
    int unsigned p0 = rd_ptr;
    bit ok;
    clear_exp(); model_stream(b); send_bytes(b); wait_done(500, ok);
    n_checks++;
    if (!ok || rd_ptr - p0 != 6) begin n_fail++; $display("FAIL badop_popped: got %0d pops required 6", rd_ptr - p0); end
    n_checks++;
    if (rd_addr_log.size() - rb0 != exp_rd || wr_addr_log.size() != wb0) begin n_fail++; $display("FAIL badop_bus: got %0d reads %0d writes required %0d reads 0 writes", rd_addr_log.size() - rb0, wr_addr_log.size() - wb0, exp_rd); end
    n_checks++;
    if (tx_matches(tb0) !== 1'b1) begin n_fail++; $display("FAIL badop_reply: got %0d bytes required %0d", tx_log.size() - tb0, exp_tx.size()); end
  endtask

  task automatic test_tx_full_hold();
    logic [7:0] b[$] = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h00};
    logic [31:0] d = $urandom;
    int tb0 = tx_log.size(), wb0 = wr_addr_log.size(), rb0 = rd_addr_log.size();
    int t0;
    int unsigned p0;
    bit ok, seen = 0;
    b.push_back(8'h57); b.push_back(8'h44); b.push_back(8'h00); b.push_back(8'h00); b.push_back(8'h00);
    for (int k = 0; k < 4; k++) b.push_back(d[8*k +: 8]);
    clear_exp(); model_stream(b); send_bytes(b);
    for (int c = 0; c < 200 && !seen; c++) begin
      tick();
      if (rd_addr_log.size() > rb0) seen = 1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL hold_read_strobe: got none required one"); end
    tx_hold = 1;
    p0 = rd_ptr; t0 = tx_log.size();
    repeat (100) tick();
    n_checks++;
    if (rd_ptr != p0 || tx_log.size() != t0) begin n_fail++; $display("FAIL hold_stall: got %0d pops %0d pushes required 0 0", rd_ptr - p0, tx_log.size() - t0); end
    tx_hold = 0;
    wait_done(1000, ok);
    n_checks++;
    if (!ok || tx_matches(tb0) !== 1'b1) begin n_fail++; $display("FAIL hold_reply: got %0d bytes required %0d", tx_log.size() - tb0, exp_tx.size()); end
    n_checks++;
    if (wr_matches(wb0) !== 1'b1) begin n_fail++; $display("FAIL hold_followup_write: got %0d writes required %0d", wr_addr_log.size() - wb0, exp_wa.size()); end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] w[$] = '{8'h57, 8'h20, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] r[$] = '{8'h52, 8'h20, 8'h00, 8'h00, 8'h00};
    int tb0 = tx_log.size(), wb0 = wr_addr_log.size();
    int unsigned p0 = rd_ptr;
    bit ok, seen = 0;
    send_bytes(w);
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      if (rd_ptr - p0 >= 3) seen = 1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rstmid_progress: got %0d pops required 3", rd_ptr - p0); end
    reset_n = 0;
    tick();
    n_checks++;
    if (all_outs() !== 79'h0) begin n_fail++; $display("FAIL rstmid_outputs: got %h required 0", all_outs()); end
    wr_ptr = rd_ptr;
    repeat (3) tick();
    n_checks++;
    if (all_outs() !== 79'h0) begin n_fail++; $display("FAIL rstmid_outputs_held: got %h required 0", all_outs()); end
    reset_n = 1;
    tick();
    clear_exp(); model_stream(r); send_bytes(r); wait_done(500, ok);
    n_checks++;
    if (wr_addr_log.size() != wb0) begin n_fail++; $display("FAIL rstmid_no_write: got %0d writes required 0", wr_addr_log.size() - wb0); end
    n_checks++;
    if (!ok || tx_matches(tb0) !== 1'b1) begin n_fail++; $display("FAIL rstmid_read_reply: got %0d bytes required %0d", tx_log.size() - tb0, exp_tx.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[$];
    logic [31:0] d = $urandom;
    int tb0 = tx_log.size(), wb0 = wr_addr_log.size(), rb0 = rd_addr_log.size();
    bit ok;
    b = '{8'h57, 8'h81, 8'h00, 8'h00, 8'h01};
    for (int k = 0; k < 4; k++) b.push_back(d[8*k +: 8]);
    b.push_back(8'h52); b.push_back(8'h80); b.push_back(8'h00); b.push_back(8'h00); b.push_back(8'h01);
    b.push_back(8'h52); b.push_back(8'h30); b.push_back(8'h00); b.push_back(8'h00); b.push_back(8'h00);
    clear_exp(); model_stream(b); send_bytes(b); wait_done(1000, ok);
    n_checks++;
    if (!ok || tx_matches(tb0) !== 1'b1) begin n_fail++; $display("FAIL b2b_reply: got %0d bytes required %0d", tx_log.size() - tb0, exp_tx.size()); end
    n_checks++;
    if (wr_matches(wb0) !== 1'b1 || rd_addr_log.size() - rb0 != exp_rd) begin n_fail++; $display("FAIL b2b_bus: got %0d writes %0d reads required %0d %0d", wr_addr_log.size() - wb0, rd_addr_log.size() - rb0, exp_wa.size(), exp_rd); end
  endtask

  task automatic test_random();
    logic [7:0] b[$];
    int tb0 = tx_log.size(), wb0 = wr_addr_log.size(), rb0 = rd_addr_log.size();
    bit ok;
    for (int n = 0; n < 40; n++) begin
      int kind = $urandom_range(0, 9);
      logic [31:0] a = 32'h0100_0000 | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      logic [31:0] d = $urandom;
      logic [7:0] op;
      if (kind < 4) begin
        b.push_back(8'h57);
        for (int k = 0; k < 4; k++) b.push_back(a[8*k +: 8]);
        for (int k = 0; k < 4; k++) b.push_back(d[8*k +: 8]);
      end else if (kind < 9) begin
        b.push_back(8'h52);
        for (int k = 0; k < 4; k++) b.push_back(a[8*k +: 8]);
      end else begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'h57 || op == 8'h52) op = 8'h00;
        b.push_back(op);
      end
    end
    rand_rx_en = 1; rand_full_en = 1;
    clear_exp(); model_stream(b); send_bytes(b); wait_done(20000, ok);
    rand_rx_en = 0; rand_full_en = 0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rand_done: got timeout required completion"); end
    n_checks++;
    if (tx_matches(tb0) !== 1'b1) begin n_fail++; $display("FAIL rand_reply: got %0d bytes required %0d", tx_log.size() - tb0, exp_tx.size()); end
    n_checks++;
    if (wr_matches(wb0) !== 1'b1) begin n_fail++; $display("FAIL rand_writes: got %0d required %0d", wr_addr_log.size() - wb0, exp_wa.size()); end
    n_checks++;
    if (rd_addr_log.size() - rb0 != exp_rd) begin n_fail++; $display("FAIL rand_reads: got %0d required %0d", rd_addr_log.size() - rb0, exp_rd); end
  endtask

`ifdef HOST_BUS_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] p[$] = '{8'h57, 8'h00};
    logic [7:0] r[$] = '{8'h52, 8'h0C, 8'h00, 8'h00, 8'h00};
    int tb0 = tx_log.size(), wb0 = wr_addr_log.size();
    bit ok;
    send_bytes(p);
    repeat (30) tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_abort: got busy %b required 0", busy); end
    clear_exp(); model_stream(r); send_bytes(r); wait_done(500, ok);
    n_checks++;
    if (wr_addr_log.size() != wb0) begin n_fail++; $display("FAIL timeout_no_write: got %0d writes required 0", wr_addr_log.size() - wb0); end
    n_checks++;
    if (!ok || tx_matches(tb0) !== 1'b1) begin n_fail++; $display("FAIL timeout_fresh_read: got %0d bytes required %0d", tx_log.size() - tb0, exp_tx.size()); end
  endtask
`endif

  task automatic test_protocol();
    n_checks++;
    if (v_overlap != 0) begin n_fail++; $display("FAIL pop_add_overlap: got %0d required 0", v_overlap); end
    n_checks++;
    if (v_be != 0) begin n_fail++; $display("FAIL byteena_rule: got %0d violations required 0", v_be); end
    n_checks++;
    if (v_we_t != 0) begin n_fail++; $display("FAIL write_strobe_timing: got %0d violations required 0", v_we_t); end
    n_checks++;
    if (v_re_t != 0) begin n_fail++; $display("FAIL read_strobe_timing: got %0d violations required 0", v_re_t); end
    n_checks++;
    if (v_pop_b2b != 0 || v_add_b2b != 0) begin n_fail++; $display("FAIL byte_pacing: got %0d/%0d violations required 0", v_pop_b2b, v_add_b2b); end
  endtask

  initial begin
    repeat (3) tick();
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_tx_full_hold();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
`ifdef HOST_BUS_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
